// File: rtl/decoder.sv
// rtl/decoder.sv - instruction decoder with external-data wait-branch handshake (option: DECODER_DVAL_SYNC_EN)
module decoder #(
  parameter int datalength = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] opcode,
  input  logic       Wready,
  input  logic       dataval,
  output logic       PCincr,
  output logic       INen,
  output logic       ALUfunc,
  output logic       imm,
  output logic       w
);

  // datalength only sizes the surrounding datapath; reject widths that datapath cannot use
  if (datalength < 1 || datalength > 32) begin : g_bad_datalength
    $error("decoder: datalength must be in 1..32");
  end

  typedef enum logic {
    READY = 1'b0,
    TAKEN = 1'b1
  } hs_state_t;

  hs_state_t state;
  logic      dval;
  logic      accept;

`ifdef DECODER_DVAL_SYNC_EN
  logic dval_meta;
  logic dval_sync;

  // two-flop synchronizer for the asynchronous data-valid switch
  always_ff @(posedge clk) begin
    if (reset) begin
      dval_meta <= 1'b0;
      dval_sync <= 1'b0;
    end else begin
      dval_meta <= dataval;
      dval_sync <= dval_meta;
    end
  end

  assign dval = dval_sync;
`else
  assign dval = dataval;
`endif

  // a wait-branch consumes at most one data-valid pulse; reset suppresses acceptance
  assign accept = !reset && (state == READY) && (opcode == 2'b11) && Wready && dval;

  // handshake FSM: arm on acceptance, re-arm only once data-valid has dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= READY;
    end else begin
      case (state)
        READY:   if (accept) state <= TAKEN;
        TAKEN:   if (!dval) state <= READY;
        default: state <= READY;
      endcase
    end
  end

  // control decode; unknown opcodes fall through to the reset values
  always_comb begin
    w       = 1'b0;
    imm     = 1'b0;
    ALUfunc = 1'b0;
    PCincr  = 1'b1;
    INen    = 1'b0;
    if (!reset) begin
      case (opcode)
        2'b00: begin
          w    = 1'b1;
          INen = Wready;
        end
        2'b01: begin
          w    = 1'b1;
          imm  = 1'b1;
          INen = Wready;
        end
        2'b10: begin
          w       = 1'b1;
          imm     = 1'b1;
          ALUfunc = 1'b1;
        end
        2'b11: begin
          PCincr = accept;
        end
        default: begin
          PCincr = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - self-checking bench for decoder
module tb_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] opcode;
  logic       Wready;
  logic       dataval;
  logic       PCincr;
  logic       INen;
  logic       ALUfunc;
  logic       imm;
  logic       w;

`ifdef DECODER_DVAL_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: one acceptance per (possibly delayed) data-valid pulse
  logic pulse_used;
  logic dv_hist1;
  logic dv_hist2;

  decoder #(.datalength(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .Wready  (Wready),
    .dataval (dataval),
    .PCincr  (PCincr),
    .INen    (INen),
    .ALUfunc (ALUfunc),
    .imm     (imm),
    .w       (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic dv_eff();
    return (DLY == 0) ? dataval : dv_hist2;
  endfunction

  // expected {w, imm, ALUfunc, PCincr, INen}
  function automatic logic [4:0] model_out();
    logic [4:0] e;
    if (reset) return 5'b00010;
    case (opcode)
      2'd0: e = {4'b1001, Wready};
      2'd1: e = {4'b1101, Wready};
      2'd2: e = 5'b11110;
      default: e = {3'b000, (Wready && dv_eff() && !pulse_used), 1'b0};
    endcase
    return e;
  endfunction

  function automatic logic [4:0] outs();
    return {w, imm, ALUfunc, PCincr, INen};
  endfunction

  task automatic drive(input logic r, input logic [1:0] o, input logic wr, input logic dv);
    @(negedge clk);
    reset   = r;
    opcode  = o;
    Wready  = wr;
    dataval = dv;
    #2;
  endtask

  task automatic advance();
    logic d;
    @(posedge clk);
    d = dv_eff();
    if (reset) begin
      pulse_used = 1'b0;
      dv_hist1   = 1'b0;
      dv_hist2   = 1'b0;
    end else begin
      if (opcode == 2'd3 && Wready && d && !pulse_used) pulse_used = 1'b1;
      else if (!d) pulse_used = 1'b0;
      dv_hist2 = dv_hist1;
      dv_hist1 = dataval;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 1'($urandom), 1'($urandom));
      tests_run++;
      if (outs() !== 5'b00010) begin
        tests_failed++;
        $display("FAIL reset_op0 cycle %0d: got %b expected 00010", i, outs());
      end
      advance();
    end
    for (int o = 0; o < 4; o++) begin
      drive(1'b1, 2'(o), 1'b1, 1'b1);
      tests_run++;
      if (outs() !== 5'b00010) begin
        tests_failed++;
        $display("FAIL reset_op%0d: got %b expected 00010", o, outs());
      end
      advance();
    end
  endtask

  task automatic test_decode();
    logic [4:0] exp_tab [3] = '{5'b10010, 5'b11010, 5'b11110};
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    advance();
    for (int o = 0; o < 3; o++) begin
      drive(1'b0, 2'(o), 1'b0, 1'($urandom));
      tests_run++;
      if (outs() !== exp_tab[o]) begin
        tests_failed++;
        $display("FAIL decode_op%0d_wr0: got %b expected %b", o, outs(), exp_tab[o]);
      end
      advance();
    end
    drive(1'b0, 2'd1, 1'b1, 1'($urandom));
    tests_run++;
    if (outs() !== 5'b11011) begin
      tests_failed++;
      $display("FAIL decode_addi_wr1: got %b expected 11011", outs());
    end
    advance();
    drive(1'b0, 2'd10, 1'b1, 1'($urandom));
    tests_run++;
    if (outs() !== 5'b11110) begin
      tests_failed++;
      $display("FAIL decode_muli_wr1: got %b expected 11110", outs());
    end
    advance();
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    tests_run++;
    if (outs() !== 5'b10011) begin
      tests_failed++;
      $display("FAIL decode_add_wr1: got %b expected 10011", outs());
    end
    advance();
  endtask

  task automatic test_branch_nowait();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'd3, 1'b0, 1'(i % 2));
      tests_run++;
      if (outs() !== 5'b00000) begin
        tests_failed++;
        $display("FAIL branch_nowait cycle %0d: got %b expected 00000", i, outs());
      end
      advance();
    end
  endtask

  task automatic test_wait_branch();
    int ones;
    ones = 0;
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 2'd3, 1'b1, 1'(i >= 5 && i < 10));
      if (PCincr === 1'b1) ones++;
      tests_run++;
      if (PCincr !== 1'(i == 5 + DLY)) begin
        tests_failed++;
        $display("FAIL wait_branch cycle %0d: PCincr %b expected %b", i, PCincr, 1'(i == 5 + DLY));
      end
      advance();
    end
    tests_run++;
    if (ones != 1) begin
      tests_failed++;
      $display("FAIL wait_branch_count: got %0d release cycles expected 1", ones);
    end
    for (int i = 0; i <= DLY; i++) begin
      drive(1'b0, 2'd3, 1'b1, 1'b1);
      tests_run++;
      if (PCincr !== 1'(i == DLY)) begin
        tests_failed++;
        $display("FAIL wait_rearm cycle %0d: PCincr %b expected %b", i, PCincr, 1'(i == DLY));
      end
      advance();
    end
  endtask

  task automatic test_hold_high();
    logic [1:0] seq_op [8] = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b1, 2'd0, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < DLY + 2; i++) begin
      drive(1'b0, 2'd0, 1'b0, 1'b1);
      advance();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, seq_op[i], 1'b1, 1'b1);
      tests_run++;
      if (outs() !== model_out() || (seq_op[i] == 2'd3 && PCincr !== 1'(i == 0))) begin
        tests_failed++;
        $display("FAIL hold_high cycle %0d: got %b expected %b", i, outs(), model_out());
      end
      advance();
    end
  endtask

  task automatic test_reset_midwait();
    drive(1'b0, 2'd3, 1'b1, 1'b1);
    advance();
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    advance();
    for (int i = 0; i <= DLY + 1; i++) begin
      drive(1'b0, 2'd3, 1'b1, 1'b1);
      tests_run++;
      if (PCincr !== 1'(i == DLY) || outs() !== model_out()) begin
        tests_failed++;
        $display("FAIL reset_midwait cycle %0d: PCincr %b expected %b", i, PCincr, 1'(i == DLY));
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic dv;
    logic [4:0] e;
    dv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) dv = ~dv;
      drive(1'($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), dv);
      e = model_out();
      tests_run++;
      if (outs() !== e) begin
        tests_failed++;
        $display("FAIL random cycle %0d op %0d wr %b dv %b rst %b: got %b expected %b",
                 i, opcode, Wready, dataval, reset, outs(), e);
      end
      advance();
    end
  endtask

  initial begin
    reset      = 1'b1;
    opcode     = 2'd0;
    Wready     = 1'b0;
    dataval    = 1'b0;
    pulse_used = 1'b0;
    dv_hist1   = 1'b0;
    dv_hist2   = 1'b0;
    test_reset();
    test_decode();
    test_branch_nowait();
    test_wait_branch();
    test_hold_high();
    test_reset_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
